// File: rtl/fc_layer_scheduler.sv
// fc_layer_scheduler: sequences fully-connected layer engines over one shared memory port
module fc_layer_scheduler #(
    parameter int NUM_LAYERS = 3,
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_idx,
    input  logic [AW-1:0]            cfg_base,
    output logic [NUM_LAYERS-1:0]    lyr_enable,
    input  logic [NUM_LAYERS-1:0]    lyr_we,
    input  logic [NUM_LAYERS*AW-1:0] lyr_addr,
    input  logic [NUM_LAYERS*DW-1:0] lyr_out,
    input  logic [NUM_LAYERS-1:0]    lyr_com_end,
    input  logic [NUM_LAYERS-1:0]    lyr_layer_end,
    input  logic [DW-1:0]            mem_rdata,
    output logic [DW-1:0]            lyr_in,
    output logic [AW-1:0]            mem_addr,
    output logic                     mem_we,
    output logic [DW-1:0]            mem_wdata,
    output logic                     busy,
    output logic [2:0]               cur_layer,
    output logic                     done,
    output logic                     err,
    output logic [31:0]              run_cycles
);
    typedef enum logic [2:0] {IDLE, RUN, GAP, DONE, ERR} state_t;

    state_t        state;
    logic [AW-1:0] base [8];
    logic [31:0]   wdog;

    // Engine vectors padded to the full 3-bit index space so cur_layer selects cleanly
    logic [7:0]      we_pad;
    logic [7:0]      end_pad;
    logic [8*AW-1:0] addr_pad;
    logic [8*DW-1:0] out_pad;
    logic            cur_we;
    logic            cur_end;
    logic [AW-1:0]   cur_addr;
    logic [DW-1:0]   cur_out;
    logic            running;
    logic            unused_com_end;

    assign unused_com_end = ^lyr_com_end;
    assign we_pad   = 8'(lyr_we);
    assign end_pad  = 8'(lyr_layer_end);
    assign addr_pad = (8*AW)'(lyr_addr);
    assign out_pad  = (8*DW)'(lyr_out);

    // Select the active engine's signals and drive the shared port only while it runs
    always_comb begin
        cur_we     = we_pad[cur_layer];
        cur_end    = end_pad[cur_layer];
        cur_addr   = addr_pad[cur_layer*AW +: AW];
        cur_out    = out_pad[cur_layer*DW +: DW];
        running    = (state == RUN);
        lyr_enable = (running && !cur_end) ? NUM_LAYERS'(1) << cur_layer : '0;
        mem_addr   = running ? base[cur_layer] + cur_addr : '0;
        mem_we     = running ? cur_we : 1'b0;
        mem_wdata  = running ? cur_out : '0;
        lyr_in     = mem_rdata;
    end

    // Sequencer FSM with registered status outputs, base registers and watchdog
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            for (int i = 0; i < 8; i++) base[i] <= '0;
            cur_layer  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            run_cycles <= '0;
            wdog       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_we && {29'd0, cfg_idx} < 32'(NUM_LAYERS)) base[cfg_idx] <= cfg_base;
                    if (start) begin
                        state      <= RUN;
                        cur_layer  <= '0;
                        busy       <= 1'b1;
                        err        <= 1'b0;
                        run_cycles <= '0;
                        wdog       <= '0;
                    end
                end
                RUN: begin
                    wdog <= wdog + 32'd1;
                    if (run_cycles != '1) run_cycles <= run_cycles + 32'd1;
                    if (cur_end) state <= GAP;
                    else if (wdog == 32'(TIMEOUT - 1)) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end
                end
                GAP: begin
                    wdog <= '0;
                    if (cur_layer == 3'(NUM_LAYERS - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cur_layer <= cur_layer + 3'd1;
                        state     <= RUN;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_layer_scheduler.sv
// tb_fc_layer_scheduler: directed and randomized checks of the layer sequencer against a plan-based model
module tb_fc_layer_scheduler;
    localparam int NL = 3;
    localparam int TO = 40;

    logic          clk = 0, reset_n = 0, start = 0, cfg_we = 0, clr = 0;
    logic [2:0]    cfg_idx = 0;
    logic [15:0]   cfg_base = 0;
    logic [NL-1:0] lyr_enable, lyr_we = 0, lyr_com_end = 0, lyr_layer_end;
    logic [47:0]   lyr_addr = 0, lyr_out = 0;
    logic [15:0]   mem_rdata = 0, lyr_in, mem_addr, mem_wdata;
    logic          mem_we, busy, done, err;
    logic [2:0]    cur_layer;
    logic [31:0]   run_cycles;

    int          vectors = 0, miscompares = 0;
    int          lim [NL];
    int          cnt [NL];
    logic [15:0] mb [NL];

    typedef struct {bit run; logic [2:0] en; int cur; bit dn; bit er;} step_t;

    fc_layer_scheduler #(.NUM_LAYERS(NL), .AW(16), .DW(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_base(cfg_base), .lyr_enable(lyr_enable), .lyr_we(lyr_we), .lyr_addr(lyr_addr),
        .lyr_out(lyr_out), .lyr_com_end(lyr_com_end), .lyr_layer_end(lyr_layer_end),
        .mem_rdata(mem_rdata), .lyr_in(lyr_in), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .busy(busy), .cur_layer(cur_layer), .done(done), .err(err),
        .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    // Engine models: count enabled cycles, raise layer_end once the configured length is reached
    always @(posedge clk) for (int k = 0; k < NL; k++) cnt[k] <= clr ? 0 : cnt[k] + int'(lyr_enable[k]);
    always_comb for (int k = 0; k < NL; k++) lyr_layer_end[k] = (cnt[k] == lim[k]);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cfg(input logic [2:0] idx, input logic [15:0] b);
        @(negedge clk);
        cfg_we = 1; cfg_idx = idx; cfg_base = b;
        @(posedge clk);
        #1 cfg_we = 0;
        if (idx < NL) mb[idx] = b;
    endtask

    task automatic drive(input bit fixed);
        if (fixed) begin
            lyr_addr = {16'h0020, 16'h0003, 16'h0007};
            lyr_we   = 3'b111;
            lyr_out  = {16'h0aaa, 16'h0155, 16'h0bbb};
        end else begin
            lyr_addr = 48'({$urandom(), $urandom()});
            lyr_we   = 3'($urandom());
            lyr_out  = 48'({$urandom(), $urandom()});
        end
        mem_rdata = 16'($urandom());
    endtask

    // Builds the expected per-cycle plan from layer lengths, then runs and compares every cycle
    task automatic run_seq(input int l0, input int l1, input int l2, input bit fixed, input bit poke);
        step_t q[$];
        step_t s;
        int rc = 0;
        bit erx = 0;
        logic [15:0] ea;
        lim[0] = l0; lim[1] = l1; lim[2] = l2;
        for (int k = 0; k < NL && !erx; k++) begin
            int rl = (lim[k] >= TO) ? TO : lim[k] + 1;
            for (int i = 0; i < rl; i++) begin
                s = '{1, (i < lim[k]) ? 3'(1 << k) : 3'b0, k, 0, 0};
                q.push_back(s);
            end
            rc += rl;
            erx = (lim[k] >= TO);
            s = '{0, 3'b0, k, 0, erx};
            q.push_back(s);
        end
        if (!erx) begin
            s = '{0, 3'b0, NL - 1, 1, 0};
            q.push_back(s);
        end
        @(negedge clk);
        start = 1; clr = 1;
        @(posedge clk);
        #1 start = 0; clr = 0;
        foreach (q[t]) begin
            @(negedge clk);
            drive(fixed);
            if (poke) begin
                start = (t == 5); cfg_we = (t == 5); cfg_idx = 0; cfg_base = 16'hdead;
            end
            #1;
            ea = q[t].run ? mb[q[t].cur] + lyr_addr[q[t].cur*16 +: 16] : 16'h0;
            chk("lyr_enable", lyr_enable, q[t].en);
            chk("cur_layer", cur_layer, 3'(q[t].cur));
            chk("busy", busy, 1);
            chk("done", done, q[t].dn);
            chk("err", err, q[t].er);
            chk("mem_addr", mem_addr, ea);
            chk("mem_we", mem_we, q[t].run & lyr_we[q[t].cur]);
            chk("mem_wdata", mem_wdata, q[t].run ? lyr_out[q[t].cur*16 +: 16] : 16'h0);
            chk("lyr_in", lyr_in, mem_rdata);
            if (fixed && q[t].run && q[t].cur == 1 && mb[1] == 16'h0020) chk("addr_reloc", mem_addr, 16'h0023);
            if (fixed && q[t].run && q[t].cur == 2 && mb[2] == 16'hfff0) chk("addr_wrap", mem_addr, 16'h0010);
        end
        start = 0; cfg_we = 0;
        @(negedge clk);
        #1;
        chk("end_busy", busy, 0);
        chk("end_done", done, 0);
        chk("end_err", err, erx);
        chk("run_cycles", run_cycles, rc);
        chk("end_enable", lyr_enable, 0);
        chk("end_mem_we", mem_we, 0);
    endtask

    initial begin
        for (int k = 0; k < NL; k++) begin lim[k] = 1000; mb[k] = 0; end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_run_cycles", run_cycles, 0);
        chk("rst_cur_layer", cur_layer, 0);
        chk("rst_enable", lyr_enable, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(negedge clk) reset_n = 1;
        // Reset in the middle of RUN
        do_cfg(0, 16'h1111); do_cfg(1, 16'h2222); do_cfg(2, 16'h3333);
        @(negedge clk);
        start = 1; clr = 1;
        @(posedge clk);
        #1 start = 0; clr = 0;
        repeat (3) @(posedge clk);
        #1 lyr_we = 3'b111;
        #1;
        chk("pre_rst_we", mem_we, 1);
        chk("pre_rst_enable", lyr_enable, 3'b001);
        reset_n = 0;
        #1;
        chk("async_rst_enable", lyr_enable, 0);
        chk("async_rst_mem_we", mem_we, 0);
        chk("async_rst_busy", busy, 0);
        @(negedge clk) reset_n = 1;
        for (int k = 0; k < NL; k++) mb[k] = 0;
        run_seq(3, 4, 2, 1, 0);
        // Relocation and the nominal three-layer sequence
        do_cfg(0, 16'h0000); do_cfg(1, 16'h0020); do_cfg(2, 16'h0040);
        run_seq(30, 30, 30, 1, 0);
        // Randomized bases, lengths and engine traffic; out-of-range cfg writes are dropped
        for (int r = 0; r < 4; r++) begin
            do_cfg(3'($urandom_range(0, 7)), 16'($urandom()));
            do_cfg(3'($urandom_range(0, 2)), 16'($urandom()));
            run_seq($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20), 0, 0);
        end
        // Watchdog abort on layer 1, then a clean run clears err
        run_seq(5, 1000, 5, 0, 0);
        run_seq(2, 2, 2, 0, 0);
        // start and cfg_we during RUN are ignored
        run_seq(10, 10, 10, 0, 1);
        run_seq(4, 4, 4, 0, 0);
        // Address wrap and layer_end coinciding with watchdog expiry
        do_cfg(2, 16'hfff0);
        run_seq(3, 3, TO - 1, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
